// File: rtl/pcihellocore_outport.sv
// Avalon-MM parallel output port: host-writable data register with atomic
// set/clear, plus a timed pulse engine that inverts selected bits temporarily.
module pcihellocore_outport #(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int                    PULSE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_strobe,
    output logic                  pulse_busy
);

    localparam logic [1:0]  ADDR_DATA  = 2'd0;
    localparam logic [1:0]  ADDR_SET   = 2'd1;
    localparam logic [1:0]  ADDR_CLEAR = 2'd2;
    localparam logic [1:0]  ADDR_PULSE = 2'd3;

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_ACTIVE  = 1'b1;

    localparam logic [15:0] CNT_LOAD   = 16'(PULSE_CYCLES - 1);
    localparam int          MASK_RD_W  = (DATA_WIDTH > 16) ? 16 : DATA_WIDTH;

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_pulse_mask;
    logic [15:0]           r_pulse_cnt;
    logic [0:0]            r_state;
    logic                  r_overrun;
    logic [31:0]           r_readdata;
    logic                  r_out_strobe;

    logic                  w_write;
    logic [DATA_WIDTH-1:0] w_wd;
    logic [DATA_WIDTH-1:0] w_out_cur;
    logic [DATA_WIDTH-1:0] w_out_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic [DATA_WIDTH-1:0] w_mask_next;
    logic [15:0]           w_cnt_next;
    logic [0:0]            w_state_next;
    logic                  w_overrun_next;
    logic [31:0]           w_rd_next;
    logic                  w_unused_wd;

    assign w_write     = chipselect & ~write_n;
    assign w_wd        = writedata[DATA_WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    // Both operands are flops, so the port never sees a write-path decode glitch.
    assign w_out_cur = r_data ^ r_pulse_mask;

    // NOTE: every variable gets a default before any branch so always_comb never infers a latch.
    always_comb begin
        w_data_next    = r_data;
        w_mask_next    = r_pulse_mask;
        w_cnt_next     = r_pulse_cnt;
        w_state_next   = r_state;
        w_overrun_next = r_overrun;

        if (r_state == ST_ACTIVE) begin
            if (r_pulse_cnt == 16'd0) begin
                w_mask_next  = '0;
                w_state_next = ST_IDLE;
            end else begin
                w_cnt_next = r_pulse_cnt - 16'd1;
            end
        end

        if (w_write) begin
            case (address)
                ADDR_DATA:  w_data_next = w_wd;
                ADDR_SET:   w_data_next = r_data | w_wd;
                ADDR_CLEAR: w_data_next = r_data & ~w_wd;
                ADDR_PULSE: begin
                    if (writedata[31]) begin
                        w_overrun_next = 1'b0;
                    end else if (r_state == ST_ACTIVE) begin
                        // Includes the final active cycle: the engine is still busy then.
                        w_overrun_next = 1'b1;
                    end else if (w_wd != '0) begin
                        w_mask_next  = w_wd;
                        w_cnt_next   = CNT_LOAD;
                        w_state_next = ST_ACTIVE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe is registered against the next port value so it lines up with the change.
    assign w_out_next = w_data_next ^ w_mask_next;

    always_comb begin
        w_rd_next = '0;
        case (address)
            ADDR_DATA:  w_rd_next[DATA_WIDTH-1:0] = r_data;
            ADDR_SET:   w_rd_next[DATA_WIDTH-1:0] = w_out_cur;
            ADDR_CLEAR: w_rd_next = '0;
            ADDR_PULSE: begin
                w_rd_next[MASK_RD_W-1:0] = r_pulse_mask[MASK_RD_W-1:0];
                w_rd_next[16]            = (r_state == ST_ACTIVE);
                w_rd_next[17]            = r_overrun;
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the async reset also kills any pulse in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data       <= RESET_VALUE;
            r_pulse_mask <= '0;
            r_pulse_cnt  <= '0;
            r_state      <= ST_IDLE;
            r_overrun    <= 1'b0;
            r_readdata   <= '0;
            r_out_strobe <= 1'b0;
        end else begin
            r_data       <= w_data_next;
            r_pulse_mask <= w_mask_next;
            r_pulse_cnt  <= w_cnt_next;
            r_state      <= w_state_next;
            r_overrun    <= w_overrun_next;
            r_readdata   <= w_rd_next;
            r_out_strobe <= (w_out_next != w_out_cur);
        end
    end

    assign out_port   = w_out_cur;
    assign pulse_busy = (r_state == ST_ACTIVE);
    assign readdata   = r_readdata;
    assign out_strobe = r_out_strobe;

endmodule

// File: tb/tb_pcihellocore_outport.sv
// Directed bench for pcihellocore_outport: register writes, strobe, pulse
// timing, overrun handling and asynchronous reset in the middle of a pulse.
module tb_pcihellocore_outport;

    localparam int DW = 16;
    localparam int PC = 8;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = 32'd0;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic          out_strobe;
    logic          pulse_busy;

    int checks = 0;
    int errors = 0;

    pcihellocore_outport #(
        .DATA_WIDTH  (DW),
        .RESET_VALUE (16'h0000),
        .PULSE_CYCLES(PC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .out_strobe(out_strobe),
        .pulse_busy(pulse_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk_port(input string tag, input logic [DW-1:0] exp_out, input logic exp_busy);
        check({tag, "_out"},  32'(out_port),   32'(exp_out));
        check({tag, "_busy"}, 32'(pulse_busy), 32'(exp_busy));
    endtask

    initial begin
        // Reset state while reset_n is held low.
        #2;
        check("rst_out",    32'(out_port),   32'h0);
        check("rst_busy",   32'(pulse_busy), 32'h0);
        check("rst_strobe", 32'(out_strobe), 32'h0);
        check("rst_rd",     readdata,        32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // DATA write: port changes only after the accepting edge.
        address = 2'd0; writedata = 32'h0000_00A5; chipselect = 1'b1; write_n = 1'b0;
        check("pre_wr_out", 32'(out_port), 32'h0);
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        check("data_out",    32'(out_port),   32'h00A5);
        check("data_strobe", 32'(out_strobe), 32'h1);
        tick();
        check("data_strobe_off", 32'(out_strobe), 32'h0);
        check("rd_data",         readdata,        32'h0000_00A5);

        // SET, CLEAR, then a same-value rewrite.
        wr(2'd1, 32'h0000_0F00);
        check("set_out",    32'(out_port),   32'h0FA5);
        check("set_strobe", 32'(out_strobe), 32'h1);
        wr(2'd2, 32'h0000_0005);
        check("clr_out",    32'(out_port),   32'h0FA0);
        check("clr_strobe", 32'(out_strobe), 32'h1);
        wr(2'd0, 32'hFFFF_0FA0);
        check("same_out",    32'(out_port),   32'h0FA0);
        check("same_strobe", 32'(out_strobe), 32'h0);
        address = 2'd1;
        tick();
        check("rd_port", readdata, 32'h0000_0FA0);
        address = 2'd2;
        tick();
        check("rd_clear_addr", readdata, 32'h0);

        // Single pulse on bit 0 with data cleared.
        wr(2'd0, 32'h0);
        tick();
        wr(2'd3, 32'h0000_0001);
        chk_port("pulse_c1", 16'h0001, 1'b1);
        check("pulse_start_strobe", 32'(out_strobe), 32'h1);
        for (int i = 2; i <= PC; i++) begin
            tick();
            chk_port($sformatf("pulse_c%0d", i), 16'h0001, 1'b1);
            check($sformatf("pulse_c%0d_strobe", i), 32'(out_strobe), 32'h0);
        end
        tick();
        chk_port("pulse_end", 16'h0000, 1'b0);
        check("pulse_end_strobe", 32'(out_strobe), 32'h1);
        tick();
        check("pulse_idle_strobe", 32'(out_strobe), 32'h0);

        // Overrun: second PULSE mid-pulse and on the last active cycle.
        wr(2'd3, 32'h0000_0001);
        wr(2'd3, 32'h0000_0002);
        chk_port("ovr_drop", 16'h0001, 1'b1);
        tick();
        check("rd_ovr_set", readdata, 32'h0003_0001);
        wr(2'd3, 32'h8000_0000);
        tick();
        check("rd_ovr_clr", readdata, 32'h0001_0001);
        tick(); tick(); tick();
        chk_port("last_active", 16'h0001, 1'b1);
        wr(2'd3, 32'h0000_0004);
        chk_port("last_drop", 16'h0000, 1'b0);
        tick();
        check("rd_ovr_last", readdata, 32'h0002_0000);
        wr(2'd3, 32'h8000_0004);
        chk_port("bit31_nopulse", 16'h0000, 1'b0);
        tick();
        check("rd_bit31_clr", readdata, 32'h0);
        wr(2'd3, 32'h0);
        chk_port("zero_mask", 16'h0000, 1'b0);

        // SET of the pulsed bit during the pulse.
        wr(2'd3, 32'h0000_0001);
        chk_port("setp_c1", 16'h0001, 1'b1);
        wr(2'd1, 32'h0000_0001);
        chk_port("setp_c2", 16'h0000, 1'b1);
        for (int i = 3; i <= PC; i++) begin
            tick();
            chk_port($sformatf("setp_c%0d", i), 16'h0000, 1'b1);
        end
        tick();
        chk_port("setp_end", 16'h0001, 1'b0);

        // Asynchronous reset in the middle of a pulse with overrun pending.
        wr(2'd0, 32'h0000_00F0);
        wr(2'd3, 32'h0000_000F);
        chk_port("rstp_c1", 16'h00FF, 1'b1);
        wr(2'd3, 32'h0000_0001);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk_port("async_rst", 16'h0000, 1'b0);
        check("async_rst_rd",     readdata,        32'h0);
        check("async_rst_strobe", 32'(out_strobe), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rd_after_rst", readdata, 32'h0);

        // Fresh pulse after reset runs the full length.
        wr(2'd3, 32'h0000_0002);
        chk_port("post_c1", 16'h0002, 1'b1);
        for (int i = 2; i <= PC; i++) begin
            tick();
            chk_port($sformatf("post_c%0d", i), 16'h0002, 1'b1);
        end
        tick();
        chk_port("post_end", 16'h0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcihellocore_outport.md
Name: pcihellocore_outport

Overview:
- Avalon-MM slave parallel output port; the write-direction counterpart of the core's PIO input port.
- Drives a 16-bit out_port from a host-writable data register.
- Provides atomic bit-set and bit-clear registers, plus a timed pulse engine that inverts selected bits for a fixed number of cycles and then restores them.
- Sits on the PCIe-to-Avalon bridge fabric; out_port goes to board LEDs / GPIO.

Parameters:
- DATA_WIDTH, 16: width of out_port and of the data register; legal range 1..31.
- RESET_VALUE, 16'h0000: value of the data register, and therefore of out_port, after reset.
- PULSE_CYCLES, 8: number of clk cycles a pulse inversion stays visible on out_port; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- address  input  2  register select: 0 DATA, 1 SET, 2 CLEAR, 3 PULSE.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  DATA_WIDTH  port output.
- out_strobe  output  1  one-cycle pulse whenever out_port changes value.
- pulse_busy  output  1  high while a pulse is active.

Behaviour:
- Reset (async assert, sync-to-clk deassert use): data_reg=RESET_VALUE, pulse_mask=0, pulse_cnt=0, overrun=0, readdata=0, out_strobe=0, pulse_busy=0, out_port=RESET_VALUE.
- Reset mid-pulse aborts the pulse and applies the reset values immediately; no residual inversion after reset.
- Write accepted when chipselect=1 and write_n=0. Zero wait states; one write per cycle.
- Written register updates at the accepting clock edge; out_port reflects it in the following cycle.
- Only writedata[DATA_WIDTH-1:0] is used, except PULSE bit 31.
- addr0 DATA: data_reg <= wd.
- addr1 SET: data_reg <= data_reg | wd.
- addr2 CLEAR: data_reg <= data_reg & ~wd.
- addr3 PULSE:
  - wd[31]=1: clear overrun only; no pulse is launched.
  - wd[31]=0, idle, wd mask nonzero: pulse_mask <= mask, pulse_cnt <= PULSE_CYCLES-1, busy from the next cycle.
  - wd[31]=0, mask zero: no-op.
  - wd[31]=0 while busy: write dropped, overrun <= 1 (sticky).
- out_port = data_reg XOR pulse_mask, both flops, so the output is glitch-free.
- Pulse engine has 2 states:
  - IDLE (mask=0).
  - ACTIVE: each cycle, if pulse_cnt=0, then pulse_mask <= 0 and return to IDLE; else pulse_cnt--.
  - The inversion is visible for exactly PULSE_CYCLES cycles.
  - pulse_busy is high exactly while in ACTIVE.
- Simultaneous events:
  - A PULSE write in the same cycle as the last ACTIVE cycle counts as busy: dropped, overrun set.
  - DATA/SET/CLEAR writes during ACTIVE update data_reg normally; the inversion still applies on top. When the pulse ends, out_port = the updated data_reg.
- out_strobe: registered. High for one cycle in the first cycle out_port shows a value different from its previous cycle.
  - Rewriting the same value produces no strobe.
  - Pulse start and pulse end each produce a strobe.
- Read: readdata updates every clk (read latency 1, no read side effects).
  - addr0: {0, data_reg}.
  - addr1: {0, out_port}.
  - addr2: 0.
  - addr3: {14'b0, overrun, pulse_busy, pulse_mask} with pulse_mask in bits [15:0], busy in bit 16, overrun in bit 17.
  - Unused upper bits read 0.

Test Plan:
- Reset release, then write addr0 0x00A5 -> out_port=0x0000 until the edge after the write, then 0x00A5. out_strobe high exactly one cycle. readdata at addr0 is 0x000000A5 one cycle after address is presented.
- From 0x00A5, write SET 0x0F00 then CLEAR 0x0005 -> out_port 0x0FA5 then 0x0FA0. Rewrite DATA 0x0FA0 -> no out_strobe.
- PULSE 0x0001 with data 0x0000, PULSE_CYCLES=8 -> out_port=0x0001 for exactly 8 cycles, then 0x0000. pulse_busy high for those 8 cycles. Two out_strobe pulses, one at start and one at end.
- Second PULSE write during ACTIVE, including on the last ACTIVE cycle -> ignored, addr3 read bit 17=1. PULSE write with wd[31]=1 -> bit 17=0 and no pulse launched.
- SET 0x0001 during an active 0x0001 pulse -> out_port=0x0000 while active, 0x0001 after the pulse ends.
- Assert reset_n low mid-pulse -> out_port=RESET_VALUE and pulse_busy=0 immediately, without waiting for clk. readdata=0, overrun=0. After release, a new pulse runs the full PULSE_CYCLES.
